// File: rtl/piece_dropper_if.sv
// rtl/piece_dropper_if.sv - drop request, board write and turn pulse bundle; anim signals exist only with DROP_ANIM_EN
interface piece_dropper_if;
  logic       drop_req;
  logic [2:0] drop_col;
  logic [1:0] player;
  logic       drop_ready;
  logic       wr_en;
  logic [2:0] wr_row;
  logic [2:0] wr_col;
  logic [1:0] wr_colour;
  logic       turn_advance;
  logic       drop_err;
  logic       board_full;
`ifdef DROP_ANIM_EN
  logic       anim_valid;
  logic [2:0] anim_row;

  modport master (
    output drop_req, drop_col, player,
    input  drop_ready, wr_en, wr_row, wr_col, wr_colour, turn_advance, drop_err, board_full,
    input  anim_valid, anim_row
  );
  modport slave (
    input  drop_req, drop_col, player,
    output drop_ready, wr_en, wr_row, wr_col, wr_colour, turn_advance, drop_err, board_full,
    output anim_valid, anim_row
  );
`else
  modport master (
    output drop_req, drop_col, player,
    input  drop_ready, wr_en, wr_row, wr_col, wr_colour, turn_advance, drop_err, board_full
  );
  modport slave (
    input  drop_req, drop_col, player,
    output drop_ready, wr_en, wr_row, wr_col, wr_colour, turn_advance, drop_err, board_full
  );
`endif
endinterface

// File: rtl/piece_dropper.sv
// rtl/piece_dropper.sv - column drop engine: finds lowest free row, writes the colour, pulses the turn tracker
// Optional fall animation state enabled by defining DROP_ANIM_EN.
module piece_dropper #(
  parameter int COLS       = 7,
  parameter int ROWS       = 6,
  parameter int ANIM_TICKS = 4
) (
  input  logic           clk,
  input  logic           reset,
  piece_dropper_if.slave bus
);
  localparam int              CW     = $clog2(ROWS * COLS + 1);
  localparam logic [3:0]      COLS_L = 4'(COLS);
  localparam logic [3:0]      ROWS_L = 4'(ROWS);
  localparam logic [CW-1:0]   CELLS  = CW'(ROWS * COLS);

  if (COLS < 1 || COLS > 8 || ROWS < 1 || ROWS > 8 || ANIM_TICKS < 1) begin : g_bad_cfg
    $error("piece_dropper: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_WRITE,
    S_ADVANCE
`ifdef DROP_ANIM_EN
    , S_FALL
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      col_q, col_d;
  logic [1:0]      player_q, player_d;
  logic [2:0]      row_q, row_d;
  logic [3:0]      heights_q [0:7];
  logic [3:0]      heights_d [0:7];
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
`ifdef DROP_ANIM_EN
  localparam int   TW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
  logic [2:0]      arow_q, arow_d;
  logic [TW-1:0]   tick_q, tick_d;
`endif

  logic       ready;
  logic [3:0] cur_h;
  logic       reject;

  // Out-of-range columns read an unused height slot but are always rejected.
  assign ready  = (state_q == S_IDLE) && !full_q;
  assign cur_h  = heights_q[col_q];
  assign reject = ({1'b0, col_q} >= COLS_L) || (cur_h == ROWS_L) ||
                  !(player_q == 2'b01 || player_q == 2'b10);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      player_q  <= '0;
      row_q     <= '0;
      heights_q <= '{default: '0};
      count_q   <= '0;
      full_q    <= 1'b0;
`ifdef DROP_ANIM_EN
      arow_q    <= '0;
      tick_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      player_q  <= player_d;
      row_q     <= row_d;
      heights_q <= heights_d;
      count_q   <= count_d;
      full_q    <= full_d;
`ifdef DROP_ANIM_EN
      arow_q    <= arow_d;
      tick_q    <= tick_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    player_d  = player_q;
    row_d     = row_q;
    heights_d = heights_q;
    count_d   = count_q;
    full_d    = full_q;
`ifdef DROP_ANIM_EN
    arow_d    = arow_q;
    tick_d    = tick_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.drop_req && ready) begin
          col_d    = bus.drop_col;
          player_d = bus.player;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (reject) begin
          state_d = S_IDLE;
        end else begin
          row_d = cur_h[2:0];
`ifdef DROP_ANIM_EN
          arow_d  = 3'(ROWS - 1);
          tick_d  = '0;
          state_d = S_FALL;
`else
          state_d = S_WRITE;
`endif
        end
      end
`ifdef DROP_ANIM_EN
      // Each row, including the target, is shown for ANIM_TICKS cycles.
      S_FALL: begin
        if (tick_q == TW'(ANIM_TICKS - 1)) begin
          tick_d = '0;
          if (arow_q == row_q) state_d = S_WRITE;
          else                 arow_d  = arow_q - 3'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end
`endif
      S_WRITE: begin
        if (cur_h != ROWS_L) begin
          heights_d[col_q] = cur_h + 4'd1;
          count_d          = count_q + CW'(1);
        end
        state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (count_q == CELLS) full_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.drop_ready   = ready;
    bus.wr_en        = (state_q == S_WRITE);
    bus.wr_row       = row_q;
    bus.wr_col       = col_q;
    bus.wr_colour    = player_q;
    bus.turn_advance = (state_q == S_ADVANCE);
    bus.drop_err     = (state_q == S_CHECK) && reject;
    bus.board_full   = full_q;
`ifdef DROP_ANIM_EN
    bus.anim_valid   = (state_q == S_FALL);
    bus.anim_row     = arow_q;
`endif
  end
endmodule

// File: tb/tb_piece_dropper.sv
// tb/tb_piece_dropper.sv - directed and randomized check of piece_dropper against a transaction-timeline model
module tb_piece_dropper;
  localparam int COLS = 7;
  localparam int ROWS = 6;
  localparam int AT   = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  piece_dropper_if bus ();

  piece_dropper #(.COLS(COLS), .ROWS(ROWS), .ANIM_TICKS(AT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit model_on = 1'b0;

  // Model: per-column heights plus the absolute cycle numbers at which each output event is due.
  int         cyc, ready_cyc, err_cyc, wr_cyc, ta_cyc, full_cyc, fall_cyc;
  int         m_h [8];
  int         m_cnt;
  logic [2:0] m_row, m_col;
  logic [1:0] m_colour;
  logic       e_full, e_ready, e_rej;
  int         e_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fall_len(input int row);
`ifdef DROP_ANIM_EN
    return (ROWS - row) * AT;
`else
    return 0 * row;
`endif
  endfunction

  task automatic model_reset();
    cyc = 0; ready_cyc = 0; err_cyc = -1; wr_cyc = -1; ta_cyc = -1; full_cyc = -1; fall_cyc = -1;
    for (int i = 0; i < 8; i++) m_h[i] = 0;
    m_cnt = 0;
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      e_full  = (full_cyc >= 0) && (cyc >= full_cyc);
      e_ready = (cyc >= ready_cyc) && !e_full;
      chk("m_drop_ready", 32'(bus.drop_ready), 32'(e_ready));
      chk("m_board_full", 32'(bus.board_full), 32'(e_full));
      chk("m_drop_err", 32'(bus.drop_err), 32'(cyc == err_cyc));
      chk("m_turn_advance", 32'(bus.turn_advance), 32'(cyc == ta_cyc));
      chk("m_wr_en", 32'(bus.wr_en), 32'(cyc == wr_cyc));
      if (cyc == wr_cyc) begin
        chk("m_wr_row", 32'(bus.wr_row), 32'(m_row));
        chk("m_wr_col", 32'(bus.wr_col), 32'(m_col));
        chk("m_wr_colour", 32'(bus.wr_colour), 32'(m_colour));
      end
`ifdef DROP_ANIM_EN
      chk("m_anim_valid", 32'(bus.anim_valid), 32'(fall_cyc >= 0 && cyc >= fall_cyc && cyc < wr_cyc));
      if (fall_cyc >= 0 && cyc >= fall_cyc && cyc < wr_cyc)
        chk("m_anim_row", 32'(bus.anim_row), 32'(ROWS - 1 - (cyc - fall_cyc) / AT));
`endif
      if (bus.drop_req && e_ready) begin
        e_c   = int'(bus.drop_col);
        e_rej = (e_c >= COLS) || (m_h[e_c] >= ROWS) || !(bus.player == 2'b01 || bus.player == 2'b10);
        if (e_rej) begin
          err_cyc   = cyc + 1;
          ready_cyc = cyc + 2;
        end else begin
          m_row     = 3'(m_h[e_c]);
          m_col     = bus.drop_col;
          m_colour  = bus.player;
          fall_cyc  = cyc + 2;
          wr_cyc    = cyc + 2 + fall_len(m_h[e_c]);
          ta_cyc    = wr_cyc + 1;
          ready_cyc = wr_cyc + 2;
          m_h[e_c]++;
          m_cnt++;
          if (m_cnt == ROWS * COLS) full_cyc = ready_cyc;
        end
      end
      cyc++;
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_drop_ready"}, 32'(bus.drop_ready), 32'd1);
    chk({tag, "_board_full"}, 32'(bus.board_full), 32'd0);
    chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
    chk({tag, "_wr_row"}, 32'(bus.wr_row), 32'd0);
    chk({tag, "_wr_col"}, 32'(bus.wr_col), 32'd0);
    chk({tag, "_wr_colour"}, 32'(bus.wr_colour), 32'd0);
    chk({tag, "_turn_advance"}, 32'(bus.turn_advance), 32'd0);
    chk({tag, "_drop_err"}, 32'(bus.drop_err), 32'd0);
`ifdef DROP_ANIM_EN
    chk({tag, "_anim_valid"}, 32'(bus.anim_valid), 32'd0);
    chk({tag, "_anim_row"}, 32'(bus.anim_row), 32'd0);
`endif
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    bus.drop_req = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1 reset_checks("rst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 model_on = 1'b1;
  endtask

  task automatic do_drop(input logic [2:0] col, input logic [1:0] pl, input bit ok, input int row);
    @(posedge clk); #2;
    bus.drop_req = 1'b1; bus.drop_col = col; bus.player = pl;
    @(negedge clk);
    chk("accept_ready", 32'(bus.drop_ready), 32'd1);
    @(posedge clk); #2;
    bus.drop_req = 1'b0;
    @(negedge clk);
    chk("check_drop_err", 32'(bus.drop_err), 32'(!ok));
    if (ok) begin
      repeat (fall_len(row)) @(negedge clk);
      @(negedge clk);
      chk("write_wr_en", 32'(bus.wr_en), 32'd1);
      chk("write_wr_row", 32'(bus.wr_row), 32'(row));
      chk("write_wr_col", 32'(bus.wr_col), 32'(col));
      chk("write_wr_colour", 32'(bus.wr_colour), 32'(pl));
      @(negedge clk);
      chk("adv_turn_advance", 32'(bus.turn_advance), 32'd1);
      @(negedge clk);
    end else begin
      @(negedge clk);
      chk("rej_ready_again", 32'(bus.drop_ready), 32'd1);
      chk("rej_no_wr", 32'(bus.wr_en), 32'd0);
    end
  endtask

  task automatic reset_during(input int off);
    @(posedge clk); #2;
    bus.drop_req = 1'b1; bus.drop_col = 3'd2; bus.player = 2'b01;
    @(negedge clk);
    @(posedge clk); #2;
    bus.drop_req = 1'b0;
    repeat (off - 1 + fall_len(0)) @(posedge clk);
    #2;
    chk("pre_rst_wr_en", 32'(bus.wr_en), 32'(off == 2));
    chk("pre_rst_turn_adv", 32'(bus.turn_advance), 32'(off == 3));
    model_on = 1'b0;
    reset = 1'b1;
    #1 reset_checks("midrst");
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1 model_on = 1'b1;
    do_drop(3'd2, 2'b10, 1'b1, 0);
  endtask

  initial begin
    bus.drop_req = 1'b0; bus.drop_col = '0; bus.player = '0;
    model_reset();
    #1 reset = 1'b1;
    #1 reset_checks("por");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 model_on = 1'b1;

    do_drop(3'd3, 2'b01, 1'b1, 0);
    for (int i = 0; i < ROWS; i++) do_drop(3'd0, (i % 2) ? 2'b10 : 2'b01, 1'b1, i);
    do_drop(3'd0, 2'b01, 1'b0, 0);
    do_drop(3'd7, 2'b01, 1'b0, 0);
    do_drop(3'd1, 2'b00, 1'b0, 0);
    do_drop(3'd1, 2'b11, 1'b0, 0);
    do_drop(3'd1, 2'b10, 1'b1, 0);

    reset_during(2);
    reset_during(3);

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      bus.drop_req = ($urandom_range(0, 2) != 0);
      bus.drop_col = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) bus.player = 2'($urandom_range(0, 3));
      else                           bus.player = $urandom_range(0, 1) ? 2'b01 : 2'b10;
    end
    @(posedge clk); #2;
    bus.drop_req = 1'b0;
    repeat (40) @(negedge clk);

    do_reset();
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        do_drop(3'(c), ((c * ROWS + r) % 2) ? 2'b10 : 2'b01, 1'b1, r);
    chk("full_board_full", 32'(bus.board_full), 32'd1);
    chk("full_drop_ready", 32'(bus.drop_ready), 32'd0);
    @(posedge clk); #2;
    bus.drop_req = 1'b1; bus.drop_col = 3'd0; bus.player = 2'b01;
    repeat (6) begin
      @(negedge clk);
      chk("full_ignored_wr", 32'(bus.wr_en), 32'd0);
      chk("full_ignored_err", 32'(bus.drop_err), 32'd0);
    end
    bus.drop_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
